// File: rtl/peripheral_mult.sv
// peripheral_mult -- register-mapped 16x16 unsigned shift-add multiplier.
//
// Software writes operands A (0x0) and B (0x2), then writes INIT (0x4) with
// bit0=1 to start. The FSM snapshots A/B and runs 16 shift-add steps, one
// per clock. After the last step it raises done. The 32-bit product is
// readable at 0x6 (low half) and 0x8 (high half). DONE status is at 0xA.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst    in   1  synchronous active-high reset
//   d_in   in  16  write data
//   cs     in   1  chip select; qualifies writes only
//   addr   in   4  register address (even addresses mapped)
//   rd     in   1  read enable; d_out is combinational from addr
//   wr     in   1  write enable
//   d_out  out 16  read data; zero when rd=0 or addr unmapped
module peripheral_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out
);

  localparam logic [3:0] ADDR_A     = 4'h0;
  localparam logic [3:0] ADDR_B     = 4'h2;
  localparam logic [3:0] ADDR_INIT  = 4'h4;
  localparam logic [3:0] ADDR_PP_LO = 4'h6;
  localparam logic [3:0] ADDR_PP_HI = 4'h8;
  localparam logic [3:0] ADDR_DONE  = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state_q,   state_d;
  logic [15:0] a_q,       a_d;
  logic [15:0] b_q,       b_d;
  logic [31:0] op_a_q,    op_a_d;     // multiplicand, shifted left each step
  logic [15:0] op_b_q,    op_b_d;     // multiplier, shifted right each step
  logic [31:0] product_q, product_d;
  logic [3:0]  count_q,   count_d;    // steps already completed in RUN
  logic        done_q,    done_d;

  logic we;
  logic start;

  // Next-state and datapath.
  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    product_d = product_q;
    count_d   = count_q;
    done_d    = done_q;

    we = cs & wr;

    if (we && (addr == ADDR_A)) a_d = d_in;
    if (we && (addr == ADDR_B)) b_d = d_in;

    // INIT during RUN is ignored, so a held INIT write starts one operation.
    start = we && (addr == ADDR_INIT) && d_in[0] && (state_q != S_RUN);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_a_d    = {16'h0000, a_q};
          op_b_d    = b_q;
          product_d = '0;
          count_d   = '0;
          done_d    = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (op_b_q[0]) product_d = product_q + op_a_q;
        op_a_d  = op_a_q << 1;
        op_b_d  = op_b_q >> 1;
        count_d = count_q + 4'd1;
        // The 16th step and done share an edge.
        if (count_q == 4'd15) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its pre-edge inputs, independent of statement order.
  // NOTE: reset is synchronous; the block holds only a few scalar registers
  // and no memory array, so every flop is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      product_q <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      product_q <= product_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  // Read mux: purely combinational from rd, addr and register contents.
  // cs does not gate reads.
  always_comb begin
    d_out = '0;
    if (rd) begin
      case (addr)
        ADDR_A:     d_out = a_q;
        ADDR_B:     d_out = b_q;
        ADDR_PP_LO: d_out = product_q[15:0];
        ADDR_PP_HI: d_out = product_q[31:16];
        ADDR_DONE:  d_out = {15'h0000, done_q};
        default:    d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_mult.sv
// tb_peripheral_mult -- self-checking bench for peripheral_mult.
// Expected values come from a reference model. The model multiplies the
// operands captured at each INIT. It holds done low for 16 clocks after
// the INIT edge.
module tb_peripheral_mult;

  localparam logic [3:0] ADDR_A     = 4'h0;
  localparam logic [3:0] ADDR_B     = 4'h2;
  localparam logic [3:0] ADDR_INIT  = 4'h4;
  localparam logic [3:0] ADDR_PP_LO = 4'h6;
  localparam logic [3:0] ADDR_PP_HI = 4'h8;
  localparam logic [3:0] ADDR_DONE  = 4'hA;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_in;
  logic        cs;
  logic [3:0]  addr;
  logic        rd;
  logic        wr;
  logic [15:0] d_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [15:0] mdl_a;
  logic [15:0] mdl_b;
  logic [31:0] mdl_prod;
  logic        mdl_done;

  peripheral_mult dut (
    .clk   (clk),
    .rst   (rst),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [15:0] d, input int n = 1);
    cs   = 1'b1;
    wr   = 1'b1;
    addr = a;
    d_in = d;
    tick(n);
    cs   = 1'b0;
    wr   = 1'b0;
    d_in = '0;
  endtask

  // Reads are sampled mid-cycle, on the falling edge, away from state changes.
  task automatic read_reg(input logic [3:0] a, output logic [15:0] v);
    @(negedge clk);
    addr = a;
    rd   = 1'b1;
    #1;
    v  = d_out;
    rd = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] v;
    read_reg(a, v);
    check(tag, v, exp);
  endtask

  // Model-side INIT: capture the product of the current operands.
  task automatic model_start();
    mdl_prod = {16'h0000, mdl_a} * {16'h0000, mdl_b};
    mdl_done = 1'b0;
  endtask

  task automatic check_result(input string tag);
    check({tag, "_pp_lo"}, dut_read(ADDR_PP_LO), mdl_prod[15:0]);
    check({tag, "_pp_hi"}, dut_read(ADDR_PP_HI), mdl_prod[31:16]);
    check({tag, "_done"},  dut_read(ADDR_DONE),  {15'h0000, mdl_done});
  endtask

  function automatic logic [15:0] dut_read(input logic [3:0] a);
    // Combinational peek; used only while the design is stable (no run active).
    logic [15:0] v;
    v = '0;
    case (a)
      ADDR_PP_LO: v = dut.product_q[15:0];
      ADDR_PP_HI: v = dut.product_q[31:16];
      ADDR_DONE:  v = {15'h0000, dut.done_q};
      default:    v = '0;
    endcase
    return v;
  endfunction

  // Poll DONE up to a bounded number of cycles; a timeout counts as a failure.
  task automatic wait_done(input string tag);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 20; i++) begin
      read_reg(ADDR_DONE, v);
      if (v == 16'h0001) break;
      tick(1);
    end
    check({tag, "_wait_done"}, v, 16'h0001);
    mdl_done = 1'b1;
  endtask

  initial begin
    logic [15:0] v;
    rst  = 1'b1;
    d_in = '0;
    cs   = 1'b0;
    addr = '0;
    rd   = 1'b0;
    wr   = 1'b0;
    mdl_a = '0; mdl_b = '0; mdl_prod = '0; mdl_done = 1'b0;

    // Writes issued during reset must be ignored.
    write_reg(ADDR_A, 16'h1234, 2);
    rst = 1'b0;
    check_reg("rst_a",     ADDR_A,     16'h0000);
    check_reg("rst_b",     ADDR_B,     16'h0000);
    check_reg("rst_pp_lo", ADDR_PP_LO, 16'h0000);
    check_reg("rst_pp_hi", ADDR_PP_HI, 16'h0000);
    check_reg("rst_done",  ADDR_DONE,  16'h0000);

    // 5 * 2 with every write held for 4 cycles. INIT starts on its first edge.
    // Done must land on the 16th edge after that first edge.
    write_reg(ADDR_A, 16'd5, 4); mdl_a = 16'd5;
    write_reg(ADDR_B, 16'd2, 4); mdl_b = 16'd2;
    check_reg("rw_a", ADDR_A, 16'd5);
    check_reg("rw_b", ADDR_B, 16'd2);
    tick(1);
    write_reg(ADDR_INIT, 16'h0001, 4); model_start();
    tick(12);
    check_reg("held_init_done_e15", ADDR_DONE, 16'h0000);
    tick(1);
    check_reg("held_init_done_e16", ADDR_DONE, 16'h0001);
    mdl_done = 1'b1;
    tick(4);
    check_reg("mul5x2_pp_lo", ADDR_PP_LO, 16'h000A);
    check_reg("mul5x2_pp_hi", ADDR_PP_HI, 16'h0000);
    check_reg("mul5x2_done",  ADDR_DONE,  16'h0001);

    // INIT with bit0=0 is ignored. Writes to read-only registers are ignored.
    write_reg(ADDR_INIT, 16'hFFFE, 1);
    write_reg(ADDR_PP_LO, 16'hBEEF, 1);
    write_reg(ADDR_DONE, 16'h0000, 1);
    tick(3);
    check_reg("init0_pp_lo", ADDR_PP_LO, 16'h000A);
    check_reg("init0_done",  ADDR_DONE,  16'h0001);

    // Max operands: 0xFFFF * 0xFFFF = 0xFFFE0001.
    write_reg(ADDR_A, 16'hFFFF); mdl_a = 16'hFFFF;
    write_reg(ADDR_B, 16'hFFFF); mdl_b = 16'hFFFF;
    write_reg(ADDR_INIT, 16'h0001); model_start();
    wait_done("max");
    check_reg("max_pp_lo", ADDR_PP_LO, 16'h0001);
    check_reg("max_pp_hi", ADDR_PP_HI, 16'hFFFE);

    // Exact done timing plus a mid-run write to A, which must not disturb
    // the product.
    write_reg(ADDR_A, 16'd300); mdl_a = 16'd300;
    write_reg(ADDR_B, 16'd41);  mdl_b = 16'd41;
    write_reg(ADDR_INIT, 16'h0001); model_start();
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        write_reg(ADDR_A, 16'd7); mdl_a = 16'd7;
      end else begin
        tick(1);
      end
      if (k == 2)  check_reg("run_done_e2",  ADDR_DONE, 16'h0000);
      if (k == 15) check_reg("run_done_e15", ADDR_DONE, 16'h0000);
      if (k == 16) check_reg("run_done_e16", ADDR_DONE, 16'h0001);
    end
    mdl_done = 1'b1;
    check_reg("old_a_pp_lo", ADDR_PP_LO, mdl_prod[15:0]);
    check_reg("old_a_pp_hi", ADDR_PP_HI, mdl_prod[31:16]);
    check_reg("new_a_rb",    ADDR_A,     16'd7);

    // A second INIT after DONE with B=3: done clears, then sets again.
    write_reg(ADDR_B, 16'd3); mdl_b = 16'd3;
    write_reg(ADDR_INIT, 16'h0001); model_start();
    check_reg("reinit_done_clr", ADDR_DONE, 16'h0000);
    wait_done("reinit");
    check_reg("reinit_pp_lo", ADDR_PP_LO, 16'd21);
    check_reg("reinit_pp_hi", ADDR_PP_HI, 16'h0000);

    // Bus qualification: cs=0 blocks writes, rd=0 and unmapped reads return 0.
    write_reg(ADDR_A, 16'hAAAA); mdl_a = 16'hAAAA;
    cs = 1'b0; wr = 1'b1; addr = ADDR_A; d_in = 16'h5555;
    tick(2);
    wr = 1'b0; d_in = '0;
    check_reg("cs0_a", ADDR_A, mdl_a);
    @(negedge clk);
    addr = ADDR_A; rd = 1'b0;
    #1;
    check("rd0_dout", d_out, 16'h0000);
    check_reg("unmapped_c", 4'hC, 16'h0000);
    check_reg("unmapped_1", 4'h1, 16'h0000);

    // Reset mid-run aborts the operation and returns the FSM to IDLE.
    write_reg(ADDR_B, 16'h1357); mdl_b = 16'h1357;
    write_reg(ADDR_INIT, 16'h0001);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    mdl_a = '0; mdl_b = '0; mdl_prod = '0; mdl_done = 1'b0;
    check_reg("midrst_a",     ADDR_A,     16'h0000);
    check_reg("midrst_b",     ADDR_B,     16'h0000);
    check_reg("midrst_pp_lo", ADDR_PP_LO, 16'h0000);
    check_reg("midrst_pp_hi", ADDR_PP_HI, 16'h0000);
    check_reg("midrst_done",  ADDR_DONE,  16'h0000);
    tick(20);
    check_reg("midrst_idle_done", ADDR_DONE, 16'h0000);

    // Zero operands: product 0 with done=1. This also proves IDLE accepts INIT.
    write_reg(ADDR_INIT, 16'h0001); model_start();
    wait_done("zero");
    check_reg("zero_pp_lo", ADDR_PP_LO, 16'h0000);
    check_reg("zero_pp_hi", ADDR_PP_HI, 16'h0000);

    // Randomized operations against the model, with occasional edge operands,
    // mid-run A/B writes, and ignored INIT(0) writes.
    for (int t = 0; t < 12; t++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (t == 0) ra = 16'h0000;
      if (t == 1) rb = 16'h0000;
      if (t == 2) rb = 16'hFFFF;
      write_reg(ADDR_A, ra); mdl_a = ra;
      write_reg(ADDR_B, rb); mdl_b = rb;
      write_reg(ADDR_INIT, 16'h0001); model_start();
      if ($urandom_range(0, 1) == 1) begin
        tick($urandom_range(0, 8));
        write_reg(ADDR_A, 16'($urandom)); mdl_a = d_out;
        write_reg(ADDR_B, 16'($urandom));
      end
      wait_done("rnd");
      check_reg("rnd_pp_lo", ADDR_PP_LO, mdl_prod[15:0]);
      check_reg("rnd_pp_hi", ADDR_PP_HI, mdl_prod[31:16]);
      if ($urandom_range(0, 2) == 0) begin
        write_reg(ADDR_INIT, 16'($urandom) & 16'hFFFE);
        tick(2);
        check_reg("rnd_init0_done",  ADDR_DONE,  16'h0001);
        check_reg("rnd_init0_pp_hi", ADDR_PP_HI, mdl_prod[31:16]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
